// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter: FSM states, owner tags,
// burst counter width and the saturating increment used by the burst limit.
package dmem_arb_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnP = 2'd1,
    StOwnD = 2'd2
  } arb_state_e;

  localparam logic TAG_P = 1'b0;
  localparam logic TAG_D = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] cnt, logic [CNT_W-1:0] max);
    return (cnt < max) ? cnt + CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the dmem syncram port and the busy flag.
// The arbiter uses the slave modport; requesters and the memory sit on master.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              req_p;
  logic              we_p;
  logic [ADDR_W-1:0] addr_p;
  logic [DATA_W-1:0] wdata_p;
  logic              gnt_p;
  logic              rvalid_p;

  logic              req_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              gnt_d;
  logic              rvalid_d;

  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_data;
  logic              dmem_wren;
  logic [DATA_W-1:0] dmem_q;
  logic              busy;

  modport slave (
    input  req_p, we_p, addr_p, wdata_p, req_d, we_d, addr_d, wdata_d, dmem_q,
    output gnt_p, rvalid_p, gnt_d, rvalid_d, rdata, dmem_address, dmem_data, dmem_wren, busy
  );

  modport master (
    output req_p, we_p, addr_p, wdata_p, req_d, we_d, addr_d, wdata_d, dmem_q,
    input  gnt_p, rvalid_p, gnt_d, rvalid_d, rdata, dmem_address, dmem_data, dmem_wren, busy
  );
endinterface

// File: rtl/dmem_arb_rdpipe.sv
// Read-return pipe: RD_LAT stages of {valid, owner tag}. The tag travels with
// the read so rvalid is routed to the issuer regardless of current ownership.
module dmem_arb_rdpipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic tag,
  output logic rvalid_p,
  output logic rvalid_d,
  output logic pending
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= push;
      tag_q[0] <= tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Gated by reset so a read in flight never surfaces once reset is asserted.
  assign rvalid_p = !rst && vld_q[RD_LAT-1] && (tag_q[RD_LAT-1] == TAG_P);
  assign rvalid_d = !rst && vld_q[RD_LAT-1] && (tag_q[RD_LAT-1] == TAG_D);
  assign pending  = |vld_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the processor (P) and debug/loader (D)
// ports with a burst limit. Define DMEM_ARB_RR_EN for round-robin IDLE tie-breaks.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              grant_p, grant_d;
  logic              gnt_p, gnt_d, gnt_any;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              we_mux;
  logic              pending;
`ifdef DMEM_ARB_RR_EN
  logic              rr_q, rr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_p = 1'b0;
    grant_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req_p && bus.req_d) begin
`ifdef DMEM_ARB_RR_EN
          // Alternate the tie winner; rr_q holds the last IDLE tie winner.
          if (rr_q == TAG_D) grant_p = 1'b1;
          else               grant_d = 1'b1;
          rr_d = (rr_q == TAG_D) ? TAG_P : TAG_D;
`else
          grant_p = 1'b1;
`endif
        end else if (bus.req_p) begin
          grant_p = 1'b1;
        end else if (bus.req_d) begin
          grant_d = 1'b1;
        end
      end
      StOwnP: begin
        if (bus.req_p && (!bus.req_d || cnt_q < MaxCnt)) grant_p = 1'b1;
        else if (bus.req_d)                               grant_d = 1'b1;
      end
      StOwnD: begin
        if (bus.req_d && (!bus.req_p || cnt_q < MaxCnt)) grant_d = 1'b1;
        else if (bus.req_p)                               grant_p = 1'b1;
      end
      default: ;
    endcase

    if (grant_p) begin
      state_d = StOwnP;
      cnt_d   = (state_q == StOwnP) ? sat_inc(cnt_q, MaxCnt) : CNT_W'(1);
    end else if (grant_d) begin
      state_d = StOwnD;
      cnt_d   = (state_q == StOwnD) ? sat_inc(cnt_q, MaxCnt) : CNT_W'(1);
    end else begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_any) begin
        addr_q <= addr_mux;
        data_q <= data_mux;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) rr_q <= TAG_D;
    else     rr_q <= rr_d;
  end
`endif

  // No access may reach dmem while reset is held.
  assign gnt_p   = grant_p && !rst;
  assign gnt_d   = grant_d && !rst;
  assign gnt_any = gnt_p || gnt_d;

  assign addr_mux = grant_d ? bus.addr_d  : bus.addr_p;
  assign data_mux = grant_d ? bus.wdata_d : bus.wdata_p;
  assign we_mux   = grant_d ? bus.we_d    : bus.we_p;

  assign bus.gnt_p        = gnt_p;
  assign bus.gnt_d        = gnt_d;
  assign bus.dmem_address = gnt_any ? addr_mux : addr_q;
  assign bus.dmem_data    = gnt_any ? data_mux : data_q;
  assign bus.dmem_wren    = gnt_any && we_mux;
  assign bus.rdata        = bus.dmem_q;
  assign bus.busy         = !rst && ((state_q != StIdle) || pending);

  dmem_arb_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .push     (gnt_any && !we_mux),
    .tag      (gnt_d ? TAG_D : TAG_P),
    .rvalid_p (bus.rvalid_p),
    .rvalid_d (bus.rvalid_d),
    .pending  (pending)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a default instance (RD_LAT=1) and an
// RD_LAT=3 instance, each with its own behavioural syncram.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus3 ();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .MAX_BURST(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3), .MAX_BURST(8)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [31:0] rd1;
  logic [31:0] rd3 [0:2];

  // Syncram models: read latency 1 and 3; preloaded contents set while in reset.
  always @(posedge clk) begin
    if (rst) begin
      mem1[12'h010] <= 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) mem3[12'h020 + i] <= 32'hC0DE0000 + i;
    end else begin
      if (bus1.dmem_wren) mem1[bus1.dmem_address] <= bus1.dmem_data;
      if (bus3.dmem_wren) mem3[bus3.dmem_address] <= bus3.dmem_data;
    end
    rd1    <= mem1[bus1.dmem_address];
    rd3[0] <= mem3[bus3.dmem_address];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign bus1.dmem_q = rd1;
  assign bus3.dmem_q = rd3[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req;
    bus1.req_p = 0; bus1.we_p = 0; bus1.addr_p = '0; bus1.wdata_p = '0;
    bus1.req_d = 0; bus1.we_d = 0; bus1.addr_d = '0; bus1.wdata_d = '0;
    bus3.req_p = 0; bus3.we_p = 0; bus3.addr_p = '0; bus3.wdata_p = '0;
    bus3.req_d = 0; bus3.we_d = 0; bus3.addr_d = '0; bus3.wdata_d = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr_req();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clr_req();
    tick();
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus1.gnt_d, bus1.rvalid_p, bus1.rvalid_d, bus1.dmem_wren, bus1.busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000", {bus1.gnt_p, bus1.gnt_d, bus1.rvalid_p,
               bus1.rvalid_d, bus1.dmem_wren, bus1.busy});
    end
    total++;
    if (bus1.dmem_address !== 12'h000 || bus1.dmem_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr_data got=%h/%h exp=000/00000000", bus1.dmem_address, bus1.dmem_data);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus1.gnt_d, bus1.busy, bus3.busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_release got=%b exp=0000", {bus1.gnt_p, bus1.gnt_d, bus1.busy, bus3.busy});
    end
  endtask

  task automatic test_single_read;
    do_reset();
    bus1.req_p = 1; bus1.we_p = 0; bus1.addr_p = 12'h010;
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus1.gnt_d, bus1.dmem_wren} !== 3'b100 || bus1.dmem_address !== 12'h010) begin
      bad++;
      $display("FAIL single_grant got=%b addr=%h exp=100 addr=010", {bus1.gnt_p, bus1.gnt_d,
               bus1.dmem_wren}, bus1.dmem_address);
    end
    tick();
    clr_req();
    @(negedge clk);
    total++;
    if (bus1.rvalid_p !== 1'b1 || bus1.rvalid_d !== 1'b0 || bus1.rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_rdata got=%b%b %h exp=10 deadbeef", bus1.rvalid_p, bus1.rvalid_d, bus1.rdata);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus1.rvalid_p !== 1'b0 || bus1.rvalid_d !== 1'b0) begin
      bad++;
      $display("FAIL single_rvalid_pulse got=%b%b exp=00", bus1.rvalid_p, bus1.rvalid_d);
    end
  endtask

  task automatic test_write_read;
    do_reset();
    bus1.req_d = 1; bus1.we_d = 1; bus1.addr_d = 12'h3FF; bus1.wdata_d = 32'h00000055;
    @(negedge clk);
    total++;
    if ({bus1.gnt_d, bus1.dmem_wren} !== 2'b11 || bus1.dmem_data !== 32'h55) begin
      bad++;
      $display("FAIL wr_grant got=%b data=%h exp=11 data=00000055", {bus1.gnt_d, bus1.dmem_wren},
               bus1.dmem_data);
    end
    tick();
    clr_req();
    bus1.req_p = 1; bus1.we_p = 0; bus1.addr_p = 12'h3FF;
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus1.gnt_d, bus1.dmem_wren} !== 3'b100) begin
      bad++;
      $display("FAIL rd_after_wr_grant got=%b exp=100", {bus1.gnt_p, bus1.gnt_d, bus1.dmem_wren});
    end
    tick();
    clr_req();
    @(negedge clk);
    total++;
    if (bus1.rvalid_p !== 1'b1 || bus1.rdata !== 32'h00000055) begin
      bad++;
      $display("FAIL rd_after_wr_data got=%b %h exp=1 00000055", bus1.rvalid_p, bus1.rdata);
    end
    total++;
    if (bus1.dmem_address !== 12'h3FF || bus1.dmem_wren !== 1'b0) begin
      bad++;
      $display("FAIL addr_hold got=%h wren=%b exp=3ff wren=0", bus1.dmem_address, bus1.dmem_wren);
    end
  endtask

  task automatic test_burst;
    logic [1:0] exp_g;
    do_reset();
    bus1.req_p = 1; bus1.we_p = 1; bus1.addr_p = 12'h100; bus1.wdata_p = 32'h1;
    bus1.req_d = 1; bus1.we_d = 1; bus1.addr_d = 12'h200; bus1.wdata_d = 32'h2;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      exp_g = (((c / 8) % 2) == 0) ? 2'b10 : 2'b01;
      total++;
      if ({bus1.gnt_p, bus1.gnt_d} !== exp_g) begin
        bad++;
        $display("FAIL burst_cycle%0d got=%b exp=%b", c, {bus1.gnt_p, bus1.gnt_d}, exp_g);
      end
      tick();
    end
    clr_req();
  endtask

  task automatic test_tie_break;
    logic [1:0] w1, w2, exp2;
`ifdef DMEM_ARB_RR_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    do_reset();
    bus1.req_p = 1; bus1.we_p = 1; bus1.req_d = 1; bus1.we_d = 1;
    @(negedge clk);
    w1 = {bus1.gnt_p, bus1.gnt_d};
    tick();
    clr_req();
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus1.gnt_d} !== 2'b00) begin
      bad++;
      $display("FAIL tie_gap got=%b exp=00", {bus1.gnt_p, bus1.gnt_d});
    end
    tick();
    bus1.req_p = 1; bus1.we_p = 1; bus1.req_d = 1; bus1.we_d = 1;
    @(negedge clk);
    w2 = {bus1.gnt_p, bus1.gnt_d};
    tick();
    clr_req();
    total++;
    if (w1 !== 2'b10) begin
      bad++;
      $display("FAIL tie_first got=%b exp=10", w1);
    end
    total++;
    if (w2 !== exp2) begin
      bad++;
      $display("FAIL tie_second got=%b exp=%b", w2, exp2);
    end
  endtask

  task automatic test_handoff;
    do_reset();
    bus1.req_p = 1; bus1.we_p = 1;
    @(negedge clk);
    tick();
    bus1.req_p = 0; bus1.req_d = 1; bus1.we_d = 1; bus1.addr_d = 12'h055;
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus1.gnt_d} !== 2'b01 || bus1.dmem_address !== 12'h055) begin
      bad++;
      $display("FAIL handoff got=%b addr=%h exp=01 addr=055", {bus1.gnt_p, bus1.gnt_d},
               bus1.dmem_address);
    end
    tick();
    clr_req();
  endtask

  task automatic test_rdlat3_alternate;
    logic [1:0]  exp_g, exp_v;
    logic [31:0] exp_q;
    int          j;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus3.req_p = (k < 4) && (k % 2 == 0);
      bus3.req_d = (k < 4) && (k % 2 == 1);
      bus3.addr_p = 12'h020 + 12'(k);
      bus3.addr_d = 12'h020 + 12'(k);
      @(negedge clk);
      exp_g = (k < 4) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      j     = k - 3;
      exp_v = (j >= 0 && j < 4) ? ((j % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      exp_q = 32'hC0DE0000 + j;
      total++;
      if ({bus3.gnt_p, bus3.gnt_d} !== exp_g) begin
        bad++;
        $display("FAIL lat3_gnt_k%0d got=%b exp=%b", k, {bus3.gnt_p, bus3.gnt_d}, exp_g);
      end
      total++;
      if ({bus3.rvalid_p, bus3.rvalid_d} !== exp_v) begin
        bad++;
        $display("FAIL lat3_rvalid_k%0d got=%b exp=%b", k, {bus3.rvalid_p, bus3.rvalid_d}, exp_v);
      end
      if (exp_v != 2'b00) begin
        total++;
        if (bus3.rdata !== exp_q) begin
          bad++;
          $display("FAIL lat3_rdata_k%0d got=%h exp=%h", k, bus3.rdata, exp_q);
        end
      end
      tick();
    end
    clr_req();
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus1.req_p = 1; bus1.we_p = 0; bus1.addr_p = 12'h010;
    bus3.req_p = 1; bus3.we_p = 0; bus3.addr_p = 12'h020;
    @(negedge clk);
    total++;
    if ({bus1.gnt_p, bus3.gnt_p} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_grant got=%b exp=11", {bus1.gnt_p, bus3.gnt_p});
    end
    tick();
    clr_req();
    rst = 1'b1;
    bus1.req_d = 1; bus1.we_d = 1; bus1.addr_d = 12'h077;
    @(negedge clk);
    total++;
    if ({bus1.rvalid_p, bus1.rvalid_d, bus1.gnt_d, bus1.dmem_wren} !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_in_reset got=%b exp=0000", {bus1.rvalid_p, bus1.rvalid_d, bus1.gnt_d,
               bus1.dmem_wren});
    end
    tick();
    rst = 1'b0;
    clr_req();
    @(negedge clk);
    total++;
    if ({bus1.busy, bus3.busy, bus1.rvalid_p} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_after got=%b exp=000", {bus1.busy, bus3.busy, bus1.rvalid_p});
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({bus3.rvalid_p, bus3.rvalid_d} !== 2'b00) begin
        bad++;
        $display("FAIL rstmid_lat3_c%0d got=%b exp=00", c, {bus3.rvalid_p, bus3.rvalid_d});
      end
      tick();
      @(negedge clk);
    end
  endtask

  initial begin
    clr_req();
    test_reset();
    test_single_read();
    test_write_read();
    test_burst();
    test_tie_break();
    test_handoff();
    test_rdlat3_alternate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory between two requesters: the processor load/store path (port P) and a debug/loader port (port D) that preloads and inspects dmem. Sits between those requesters and the dmem syncram in the top-level wrapper, clocked on the dmem clock domain. Grants at most one access per cycle, enforces a burst limit so neither side starves, and routes read data back to the requester that issued the read.

## Interface
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- RD_LAT, 1, dmem read latency in cycles (address sampled to q valid); legal 1..4
- MAX_BURST, 8, max consecutive grants to one owner while the other requester waits; legal 1..255
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_p / req_d  in  1  access request, held until granted
- we_p / we_d  in  1  1 = write, 0 = read
- addr_p / addr_d  in  ADDR_W  word address
- wdata_p / wdata_d  in  DATA_W  write data
- gnt_p / gnt_d  out  1  request accepted this cycle
- rvalid_p / rvalid_d  out  1  read data valid on rdata
- rdata  out  DATA_W  read data, equal to dmem_q
- dmem_address  out  ADDR_W  to dmem address
- dmem_data  out  DATA_W  to dmem data
- dmem_wren  out  1  to dmem wren
- dmem_q  in  DATA_W  from dmem q
- busy  out  1  state ≠ IDLE or read-return pipe non-empty

## Operation
- States: IDLE, OWN_P, OWN_D. Burst counter cnt, width 8, saturating at MAX_BURST.
- IDLE: no req → stay. One req → grant it, go OWN_x, cnt=1. Both → tie-break (see Configuration).
- OWN_x: req_x and (!req_other or cnt<MAX_BURST) → grant x, cnt+1 (saturating). Else req_other → grant other, go OWN_other, cnt=1. Else neither → IDLE, no grant, cnt=0.
- At most one of gnt_p/gnt_d per cycle. gnt is combinational from req and registered state.
- dmem_address/dmem_data/dmem_wren driven combinationally from the granted requester; no grant → dmem_wren=0, address/data hold the last granted values (registered mux select).
- Granted read (we=0) pushes owner tag into the RD_LAT-deep return pipe; rvalid_x asserts exactly RD_LAT cycles later for one cycle. Writes produce no response.
- Back-to-back reads from both sides return in grant order; each rvalid is routed by its tag, never by current state.

## Timing
- Reset values: state IDLE, cnt 0, gnt_* 0, rvalid_* 0, dmem_wren 0, dmem_address 0, dmem_data 0, busy 0, return pipe cleared, RR last-winner = D.
- Grant latency 0 cycles from req when the arbiter is free; read latency grant→rvalid = RD_LAT.
- Throughput: one access per cycle sustained.
- Requester must hold req/we/addr/wdata stable until gnt; arbiter does not buffer requests.
- Reset mid-operation: in-flight reads are dropped, no rvalid after reset asserts; dmem_wren low in the reset cycle.
- Owner drops req in the same cycle the other raises it: other granted that cycle, no idle bubble.
- cnt saturates at MAX_BURST; never wraps.

## Configuration
- DMEM_ARB_RR_EN defined: IDLE ties go to the requester that did not win the last IDLE tie-break (round robin; first tie after reset → P).
- Not defined: IDLE ties always go to P (fixed priority). Burst limit applies in both builds.

## Structure
- Package dmem_arb_pkg: state encoding (IDLE/OWN_P/OWN_D), owner tag constants (TAG_P, TAG_D), counter width constant.
- One sub-module: dmem_arb_rdpipe, RD_LAT-stage shift register of {valid, tag}, synchronous clear on reset, outputs rvalid_p/rvalid_d.

## Test plan
- Reset then single P read addr 0x010 (dmem holds 0xDEADBEEF): gnt_p same cycle, rvalid_p one cycle later with rdata=0xDEADBEEF, rvalid_d stays 0.
- D writes 0x00000055 to 0x3FF, then P reads 0x3FF: dmem_wren=1 only in the D grant cycle; P read returns 0x00000055.
- Both request continuously from IDLE, MAX_BURST=8: first grant P (both builds), P granted 8 cycles, then D 8 cycles, alternating; no cycle without a grant.
- With DMEM_ARB_RR_EN: two separated simultaneous IDLE ties → winners P then D; without macro → P then P.
- RD_LAT=3, alternating P/D reads on consecutive cycles: rvalid_p/rvalid_d alternate starting 3 cycles after first grant, each with matching data.
- Reset asserted one cycle after a granted read: no rvalid_* observed; busy=0 and state IDLE the cycle after reset.
